alu_cmd_sequencer: RTL and testbench

- Initiator and consumer for the system's 16-bit-result ALU.
- Accepts an ALU command (function, operand A, operand B) from the frame-parsing controller over a valid/ready handshake.
- Drives the ALU's operand/function/enable inputs, waits for the ALU's registered result-valid, captures the 16-bit result and returns it as two bytes to the UART TX path over a valid/ready handshake.
- Guards against functions that never produce a valid result with a timeout.

---
 rtl/alu_cmd_sequencer_if.sv | 30 +++
 rtl/alu_cmd_sequencer.sv | 98 +++++++++
 tb/tb_alu_cmd_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and TX-byte signals between the ALU command sequencer and its neighbours.
// The master side is the sequencer; the slave side is the parser, ALU and UART TX path.
interface alu_cmd_sequencer_if;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [3:0]  CMD_FUN;
  logic [7:0]  CMD_A;
  logic [7:0]  CMD_B;
  logic [7:0]  ALU_A;
  logic [7:0]  ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VALID;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic        BUSY;
  logic        ERR_TIMEOUT;

  modport master (
    input  CMD_VALID, CMD_FUN, CMD_A, CMD_B, ALU_OUT, ALU_OUT_VALID, TX_READY,
    output CMD_READY, ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_DATA, TX_VALID, BUSY, ERR_TIMEOUT
  );

  modport slave (
    output CMD_VALID, CMD_FUN, CMD_A, CMD_B, ALU_OUT, ALU_OUT_VALID, TX_READY,
    input  CMD_READY, ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_DATA, TX_VALID, BUSY, ERR_TIMEOUT
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issues one ALU command at a time, waits (bounded) for the registered result and
// returns the 16-bit result to the UART TX path as two bytes.
module alu_cmd_sequencer #(
  parameter int TIMEOUT_CYC = 15,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  alu_cmd_sequencer_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SEND_1, SEND_2} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [15:0]   result;

  function automatic logic [7:0] first_byte(input logic [15:0] r);
    return MSB_FIRST ? r[15:8] : r[7:0];
  endfunction

  function automatic logic [7:0] second_byte(input logic [15:0] r);
    return MSB_FIRST ? r[7:0] : r[15:8];
  endfunction

  assign bus.CMD_READY = (state == IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state           <= IDLE;
      timer           <= '0;
      result          <= '0;
      bus.ALU_A       <= '0;
      bus.ALU_B       <= '0;
      bus.ALU_FUN     <= '0;
      bus.ALU_EN      <= 1'b0;
      bus.TX_DATA     <= '0;
      bus.TX_VALID    <= 1'b0;
      bus.BUSY        <= 1'b0;
      bus.ERR_TIMEOUT <= 1'b0;
    end else begin
      bus.ALU_EN      <= 1'b0;
      bus.ERR_TIMEOUT <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.CMD_VALID) begin
            bus.ALU_A   <= bus.CMD_A;
            bus.ALU_B   <= bus.CMD_B;
            bus.ALU_FUN <= bus.CMD_FUN;
            bus.ALU_EN  <= 1'b1;
            bus.BUSY    <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A result arriving on the last allowed cycle still wins over the abort.
          if (bus.ALU_OUT_VALID) begin
            result       <= bus.ALU_OUT;
            bus.TX_DATA  <= first_byte(bus.ALU_OUT);
            bus.TX_VALID <= 1'b1;
            state        <= SEND_1;
          end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
            bus.ERR_TIMEOUT <= 1'b1;
            bus.BUSY        <= 1'b0;
            state           <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SEND_1: begin
          if (bus.TX_READY) begin
            bus.TX_DATA <= second_byte(result);
            state       <= SEND_2;
          end
        end
        SEND_2: begin
          if (bus.TX_READY) begin
            bus.TX_VALID <= 1'b0;
            bus.BUSY     <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          bus.TX_VALID <= 1'b0;
          bus.BUSY     <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: an LSB-first and an MSB-first instance, each
// with a small registered ALU, checked every cycle against a transaction-level model.
module tb_alu_cmd_sequencer;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if b0();
  alu_cmd_sequencer_if b1();

  alu_cmd_sequencer #(.TIMEOUT_CYC(TMO), .MSB_FIRST(1'b0)) u_lsb (.CLK(clk), .RST(rst), .bus(b0));
  alu_cmd_sequencer #(.TIMEOUT_CYC(TMO), .MSB_FIRST(1'b1)) u_msb (.CLK(clk), .RST(rst), .bus(b1));

  // ALU behaviour: 0 add, 1 sub, 2 mul, 3 and, 4 or, 5 xor, others pass A; 4'hF never valid.
  function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'h0:    return {8'h00, a} + {8'h00, b};
      4'h1:    return {8'h00, a} - {8'h00, b};
      4'h2:    return a * b;
      4'h3:    return {8'h00, a & b};
      4'h4:    return {8'h00, a | b};
      4'h5:    return {8'h00, a ^ b};
      default: return {8'h00, a};
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      b0.ALU_OUT_VALID <= 1'b0;
      b0.ALU_OUT       <= 16'h0000;
      b1.ALU_OUT_VALID <= 1'b0;
      b1.ALU_OUT       <= 16'h0000;
    end else begin
      b0.ALU_OUT_VALID <= b0.ALU_EN && (b0.ALU_FUN != 4'hF);
      b0.ALU_OUT       <= alu_ref(b0.ALU_FUN, b0.ALU_A, b0.ALU_B);
      b1.ALU_OUT_VALID <= b1.ALU_EN && (b1.ALU_FUN != 4'hF);
      b1.ALU_OUT       <= alu_ref(b1.ALU_FUN, b1.ALU_A, b1.ALU_B);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", nm, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Transaction model: pending enable, expected operands, timeout countdown, byte queues.
  logic       en_due [2];
  logic [7:0] ea [2];
  logic [7:0] eb [2];
  logic [3:0] ef [2];
  int         tmo [2];
  logic [7:0] q0[$], q1[$], obs0[$], obs1[$];

  task automatic mon(input int k, input logic r, input logic cv, input logic cr,
                     input logic [3:0] cf, input logic [7:0] ca, input logic [7:0] cb,
                     input logic en, input logic [7:0] aa, input logic [7:0] ab, input logic [3:0] af,
                     input logic tv, input logic tr, input logic [7:0] td,
                     input logic bz, input logic er);
    logic [15:0] res;
    logic [7:0]  exp_b;
    logic        exp_err;
    int          qsz;
    if (r) begin
      chk1("rst_cmd_ready", cr, 1'b1);
      chk1("rst_tx_valid", tv, 1'b0);
      chk1("rst_busy", bz, 1'b0);
      chk1("rst_alu_en", en, 1'b0);
      chk1("rst_err", er, 1'b0);
      en_due[k] = 1'b0;
      tmo[k] = -1;
      if (k == 0) q0.delete(); else q1.delete();
      return;
    end
    chk1("alu_en_timing", en, en_due[k]);
    if (en_due[k]) begin
      chk8("alu_a", aa, ea[k]);
      chk8("alu_b", ab, eb[k]);
      chk8("alu_fun", {4'h0, af}, {4'h0, ef[k]});
    end
    en_due[k] = 1'b0;
    if (tmo[k] > 0) tmo[k]--;
    exp_err = (tmo[k] == 0);
    if (tmo[k] == 0) tmo[k] = -1;
    chk1("err_timeout", er, exp_err);
    chk1("busy_vs_idle", bz, !cr);
    if (tv) begin
      qsz = (k == 0) ? q0.size() : q1.size();
      if (qsz == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stale_byte: port %0d presents 0x%02h, expected no byte", k, td);
      end else begin
        exp_b = (k == 0) ? q0[0] : q1[0];
        chk8("tx_data", td, exp_b);
        if (tr) begin
          if (k == 0) begin void'(q0.pop_front()); obs0.push_back(td); end
          else        begin void'(q1.pop_front()); obs1.push_back(td); end
        end
      end
    end
    if (cv && cr) begin
      en_due[k] = 1'b1;
      ea[k] = ca;
      eb[k] = cb;
      ef[k] = cf;
      if (cf == 4'hF) begin
        tmo[k] = TMO + 2;
      end else begin
        res = alu_ref(cf, ca, cb);
        if (k == 0) begin q0.push_back(res[7:0]);  q0.push_back(res[15:8]); end
        else        begin q1.push_back(res[15:8]); q1.push_back(res[7:0]);  end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon(0, rst, b0.CMD_VALID, b0.CMD_READY, b0.CMD_FUN, b0.CMD_A, b0.CMD_B,
        b0.ALU_EN, b0.ALU_A, b0.ALU_B, b0.ALU_FUN, b0.TX_VALID, b0.TX_READY, b0.TX_DATA,
        b0.BUSY, b0.ERR_TIMEOUT);
    mon(1, rst, b1.CMD_VALID, b1.CMD_READY, b1.CMD_FUN, b1.CMD_A, b1.CMD_B,
        b1.ALU_EN, b1.ALU_A, b1.ALU_B, b1.ALU_FUN, b1.TX_VALID, b1.TX_READY, b1.TX_DATA,
        b1.BUSY, b1.ERR_TIMEOUT);
    @(posedge clk);
    #1;
  endtask

  task automatic cmd0(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    b0.CMD_FUN = f; b0.CMD_A = a; b0.CMD_B = b; b0.CMD_VALID = 1'b1;
  endtask

  task automatic wait_tx0();
    for (int i = 0; i < 20 && !b0.TX_VALID; i++) tick();
  endtask

  task automatic wait_idle0();
    for (int i = 0; i < 40 && b0.BUSY; i++) tick();
  endtask

  initial begin
    int lat;
    b0.CMD_VALID = 1'b0; b0.CMD_FUN = 4'h0; b0.CMD_A = 8'h00; b0.CMD_B = 8'h00; b0.TX_READY = 1'b0;
    b1.CMD_VALID = 1'b0; b1.CMD_FUN = 4'h0; b1.CMD_A = 8'h00; b1.CMD_B = 8'h00; b1.TX_READY = 1'b0;
    for (int k = 0; k < 2; k++) begin en_due[k] = 1'b0; tmo[k] = -1; end

    #3;
    chk1("init_cmd_ready", b0.CMD_READY, 1'b1);
    chk1("init_busy", b0.BUSY, 1'b0);
    chk1("init_tx_valid", b0.TX_VALID, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Test 1: add with minimum latency
    b0.TX_READY = 1'b1;
    cmd0(4'h0, 8'h25, 8'h17);
    tick();
    b0.CMD_VALID = 1'b0;
    chk1("t1_en_c1", b0.ALU_EN, 1'b1);
    chk8("t1_alu_a", b0.ALU_A, 8'h25);
    chk8("t1_alu_b", b0.ALU_B, 8'h17);
    tick();
    chk1("t1_en_c2", b0.ALU_EN, 1'b0);
    tick();
    chk1("t1_txv_c3", b0.TX_VALID, 1'b1);
    chk8("t1_byte0", b0.TX_DATA, 8'h3C);
    tick();
    chk8("t1_byte1", b0.TX_DATA, 8'h00);
    tick();
    chk1("t1_busy_c5", b0.BUSY, 1'b0);
    chk1("t1_ready_c5", b0.CMD_READY, 1'b1);
    chkn("t1_nbytes", obs0.size(), 2);
    chk8("t1_obs0", obs0[0], 8'h3C);
    chk8("t1_obs1", obs0[1], 8'h00);

    // Test 2: multiply with backpressure on the first byte
    b0.TX_READY = 1'b0;
    cmd0(4'h2, 8'hFF, 8'hFF);
    tick();
    b0.CMD_VALID = 1'b0;
    wait_tx0();
    for (int i = 0; i < 5; i++) begin
      chk1("t2_hold_valid", b0.TX_VALID, 1'b1);
      chk8("t2_hold_data", b0.TX_DATA, 8'h01);
      tick();
    end
    chk8("t2_still_data", b0.TX_DATA, 8'h01);
    b0.TX_READY = 1'b1;
    wait_idle0();
    chk1("t2_idle", b0.BUSY, 1'b0);
    chkn("t2_nbytes", obs0.size(), 4);
    chk8("t2_obs2", obs0[2], 8'h01);
    chk8("t2_obs3", obs0[3], 8'hFE);

    // Test 3: function that never completes
    cmd0(4'hF, 8'h55, 8'hAA);
    tick();
    b0.CMD_VALID = 1'b0;
    lat = 1;
    for (int i = 0; i < 40 && !b0.ERR_TIMEOUT; i++) begin tick(); lat++; end
    chkn("t3_err_latency", lat, TMO + 2);
    chk1("t3_err", b0.ERR_TIMEOUT, 1'b1);
    chk1("t3_ready", b0.CMD_READY, 1'b1);
    tick();
    chk1("t3_err_pulse", b0.ERR_TIMEOUT, 1'b0);
    chkn("t3_nbytes", obs0.size(), 4);

    // Test 4: second command offered while the first is sending
    b0.TX_READY = 1'b0;
    cmd0(4'h0, 8'h10, 8'h20);
    tick();
    b0.CMD_VALID = 1'b0;
    wait_tx0();
    cmd0(4'h0, 8'h01, 8'h02);
    for (int i = 0; i < 3; i++) begin
      chk1("t4_blocked", b0.CMD_READY, 1'b0);
      tick();
    end
    b0.TX_READY = 1'b1;
    for (int i = 0; i < 20 && !b0.CMD_READY; i++) tick();
    chk1("t4_ready", b0.CMD_READY, 1'b1);
    chk1("t4_txv_idle", b0.TX_VALID, 1'b0);
    tick();
    b0.CMD_VALID = 1'b0;
    chk1("t4_en", b0.ALU_EN, 1'b1);
    chk8("t4_alu_a", b0.ALU_A, 8'h01);
    wait_idle0();
    chkn("t4_nbytes", obs0.size(), 8);
    chk8("t4_obs4", obs0[4], 8'h30);
    chk8("t4_obs5", obs0[5], 8'h00);
    chk8("t4_obs6", obs0[6], 8'h03);
    chk8("t4_obs7", obs0[7], 8'h00);

    // Test 5: reset while the second byte is stalled
    b0.TX_READY = 1'b0;
    cmd0(4'h0, 8'h05, 8'h06);
    tick();
    b0.CMD_VALID = 1'b0;
    wait_tx0();
    b0.TX_READY = 1'b1;
    tick();
    b0.TX_READY = 1'b0;
    tick(); tick();
    chk1("t5_send2_valid", b0.TX_VALID, 1'b1);
    chk8("t5_send2_data", b0.TX_DATA, 8'h00);
    #2 rst = 1'b1;
    #1;
    chk1("t5_async_txv", b0.TX_VALID, 1'b0);
    chk1("t5_async_busy", b0.BUSY, 1'b0);
    chk1("t5_async_en", b0.ALU_EN, 1'b0);
    chk1("t5_async_ready", b0.CMD_READY, 1'b1);
    tick();
    rst = 1'b0;
    b0.TX_READY = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk1("t5_no_stale", b0.TX_VALID, 1'b0);
    chkn("t5_nbytes", obs0.size(), 9);
    chk8("t5_obs8", obs0[8], 8'h0B);

    // Test 6: high byte first
    b1.TX_READY = 1'b1;
    b1.CMD_FUN = 4'h2; b1.CMD_A = 8'h12; b1.CMD_B = 8'h34; b1.CMD_VALID = 1'b1;
    tick();
    b1.CMD_VALID = 1'b0;
    for (int i = 0; i < 40 && b1.BUSY; i++) tick();
    tick();
    chk1("t6_idle", b1.BUSY, 1'b0);
    chkn("t6_nbytes", obs1.size(), 2);
    chk8("t6_obs0", obs1[0], 8'h03);
    chk8("t6_obs1", obs1[1], 8'hA8);

    chkn("end_q0_empty", q0.size(), 0);
    chkn("end_q1_empty", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
